pc_fetch_sequencer: RTL

- Control end of the next-PC select path: owns the PC register, generates the 2-bit next-PC select, and runs the instruction-memory fetch handshake.
- Accepts redirect requests from the execute/branch logic.
- Presents one fetched instruction at a time to the decode stage via valid/ready.
- Sits between instruction memory and decode, upstream of the existing PC select path.

---
 rtl/pc_fetch_sequencer_pkg.sv | 25 ++
 rtl/pc_fetch_sequencer_next_pc_select.sv | 34 +++
 rtl/pc_fetch_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Optional misaligned-target trap: PCFETCH_MISALIGN_TRAP_EN.
package pc_fetch_sequencer_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

  typedef enum logic [1:0] {
    PCSEL_SEQ  = 2'd0,
    PCSEL_BR   = 2'd1,
    PCSEL_JMP  = 2'd2,
    PCSEL_JALR = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_select.sv
// Next-PC priority encoder: jalr > jmp > branch > sequential.
// Purely combinational; produces the select code and the chosen target.
module next_pc_select
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  output pc_sel_e         sel,
  output logic [XLEN-1:0] target
);

  always_comb begin
    sel    = PCSEL_SEQ;
    target = pc_plus4;
    if (jalr) begin
      sel    = PCSEL_JALR;
      target = jalr_target;
    end else if (jmp) begin
      sel    = PCSEL_JMP;
      target = jmp_target;
    end else if (br_taken) begin
      sel    = PCSEL_BR;
      target = br_target;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, next-PC select and imem fetch handshake (REQ/WAIT/HOLD).
// Define PCFETCH_MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VECTOR.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_target,
  output logic [1:0]      pc_sel,
  output logic            misalign_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] next_pc;
  pc_sel_e         sel;
  logic            req_valid;
  logic            accept;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign accept      = instr_valid & instr_ready;
  assign pc_sel      = instr_valid ? sel : PCSEL_SEQ;

  // Request is withheld in the reset cycle itself.
  assign imem_req_valid = req_valid & ~rst;

  next_pc_select #(
    .XLEN(XLEN)
  ) u_next_pc_select (
    .pc_plus4    (pc_plus4),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .jalr        (jalr),
    .jalr_target (jalr_target),
    .sel         (sel),
    .target      (sel_target)
  );

`ifdef PCFETCH_MISALIGN_TRAP_EN
  logic misalign;
  logic misalign_q;

  assign misalign     = is_misaligned(sel_target[1:0]);
  assign next_pc      = misalign ? TRAP_VECTOR : sel_target;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= accept & misalign;
  end
`else
  assign next_pc      = sel_target & ~XLEN'(3);
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    req_valid = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule
